// File: rtl/prach_ditfft3_bf3.sv
// Radix-3 DIT recombine: (a, b, c) triplets -> X0 = a, X1 = b+c, X2 = b-c (swapped when INVERSE).
// Latency: 3 cycles per slot. There is no backpressure; broken triplets raise err_out and drop their pending outputs.
module prach_ditfft3_bf3 #(
    parameter bit INVERSE = 1'b0,
    parameter bit SCALE   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [17:0] din_dr,
    input  logic signed [17:0] din_di,
    input  logic               din_dv,
    input  logic               sync_in,
    output logic signed [17:0] dout_dr,
    output logic signed [17:0] dout_di,
    output logic               dout_dv,
    output logic               sync_out,
    output logic               err_out
);

    function automatic logic signed [17:0] fit(input logic signed [18:0] s);
        if (SCALE)
            fit = 18'((s + 19'sd1) >>> 1);
        else if (s > 19'sd131071)
            fit = 18'sd131071;
        else if (s < -19'sd131072)
            fit = 18'h20000;
        else
            fit = s[17:0];
    endfunction

    logic [1:0]         cnt;
    logic               s1_v, s2_v;
    logic [1:0]         s1_ph, s2_ph;
    logic signed [17:0] s1_dr, s1_di, s2_dr, s2_di;
    logic signed [17:0] x2_dr, x2_di;

    logic               err;
    logic [1:0]         in_ph;
    logic signed [18:0] p_dr, p_di, m_dr, m_di;
    logic signed [17:0] x1n_dr, x1n_di, x2n_dr, x2n_di;

    always_comb begin
        err   = (cnt != 2'd0) && (!din_dv || sync_in);
        in_ph = (din_dv && sync_in) ? 2'd0 : cnt;
        // While s2 holds b, s1 holds the matching c.
        p_dr  = {s2_dr[17], s2_dr} + {s1_dr[17], s1_dr};
        p_di  = {s2_di[17], s2_di} + {s1_di[17], s1_di};
        m_dr  = {s2_dr[17], s2_dr} - {s1_dr[17], s1_dr};
        m_di  = {s2_di[17], s2_di} - {s1_di[17], s1_di};
        x1n_dr = INVERSE ? fit(m_dr) : fit(p_dr);
        x1n_di = INVERSE ? fit(m_di) : fit(p_di);
        x2n_dr = INVERSE ? fit(p_dr) : fit(m_dr);
        x2n_di = INVERSE ? fit(p_di) : fit(m_di);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= 2'd0;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s1_ph    <= 2'd0;
            s2_ph    <= 2'd0;
            s1_dr    <= '0;
            s1_di    <= '0;
            s2_dr    <= '0;
            s2_di    <= '0;
            x2_dr    <= '0;
            x2_di    <= '0;
            dout_dr  <= '0;
            dout_di  <= '0;
            dout_dv  <= 1'b0;
            sync_out <= 1'b0;
            err_out  <= 1'b0;
        end else begin
            err_out <= err;
            if (!din_dv)
                cnt <= 2'd0;
            else if (sync_in)
                cnt <= 2'd1;
            else
                cnt <= (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;

            s1_v  <= din_dv;
            s1_ph <= in_ph;
            s1_dr <= din_dr;
            s1_di <= din_di;

            // A break at phase 2 means the b in s1 can never get its c; a is kept.
            s2_v  <= s1_v && !(err && cnt == 2'd2);
            s2_ph <= s1_ph;
            s2_dr <= s1_dr;
            s2_di <= s1_di;

            dout_dv  <= s2_v;
            sync_out <= s2_v && (s2_ph == 2'd0);
            if (s2_v) begin
                unique case (s2_ph)
                    2'd0: begin
                        dout_dr <= fit({s2_dr[17], s2_dr});
                        dout_di <= fit({s2_di[17], s2_di});
                    end
                    2'd1: begin
                        dout_dr <= x1n_dr;
                        dout_di <= x1n_di;
                        x2_dr   <= x2n_dr;
                        x2_di   <= x2n_di;
                    end
                    default: begin
                        dout_dr <= x2_dr;
                        dout_di <= x2_di;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prach_ditfft3_bf3.sv
// Directed bench for prach_ditfft3_bf3; instance 0: SCALE=0/INVERSE=0, 1: SCALE=1, 2: INVERSE=1.
module tb_prach_ditfft3_bf3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [17:0] din_dr, din_di;
    logic               din_dv, sync_in;
    logic signed [17:0] q_dr [3];
    logic signed [17:0] q_di [3];
    logic               q_dv [3];
    logic               q_sy [3];
    logic               q_er [3];

    always #5 clk = ~clk;

    prach_ditfft3_bf3 #(.INVERSE(1'b0), .SCALE(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
        .sync_in(sync_in), .dout_dr(q_dr[0]), .dout_di(q_di[0]), .dout_dv(q_dv[0]),
        .sync_out(q_sy[0]), .err_out(q_er[0]));
    prach_ditfft3_bf3 #(.INVERSE(1'b0), .SCALE(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
        .sync_in(sync_in), .dout_dr(q_dr[1]), .dout_di(q_di[1]), .dout_dv(q_dv[1]),
        .sync_out(q_sy[1]), .err_out(q_er[1]));
    prach_ditfft3_bf3 #(.INVERSE(1'b1), .SCALE(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
        .sync_in(sync_in), .dout_dr(q_dr[2]), .dout_di(q_di[2]), .dout_dv(q_dv[2]),
        .sync_out(q_sy[2]), .err_out(q_er[2]));

    int total = 0;
    int bad   = 0;

    // Stimulus table and per-cycle observations (index i = state after the edge closing input cycle i).
    int                 n;
    logic               s_dv [32];
    logic               s_sy [32];
    logic signed [17:0] s_dr [32];
    logic signed [17:0] s_di [32];
    logic               o_dv [3][32];
    logic               o_sy [3][32];
    logic               o_er [3][32];
    logic signed [17:0] o_dr [3][32];
    logic signed [17:0] o_di [3][32];

    task automatic add(input logic dv, input logic sy, input int r, input int i);
        s_dv[n] = dv;
        s_sy[n] = sy;
        s_dr[n] = r[17:0];
        s_di[n] = i[17:0];
        n++;
    endtask

    task automatic run_stim();
        for (int i = 0; i < n; i++) begin
            din_dv  = s_dv[i];
            sync_in = s_sy[i];
            din_dr  = s_dr[i];
            din_di  = s_di[i];
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                o_dv[k][i] = q_dv[k];
                o_sy[k][i] = q_sy[k];
                o_er[k][i] = q_er[k];
                o_dr[k][i] = q_dr[k];
                o_di[k][i] = q_di[k];
            end
        end
        din_dv  = 1'b0;
        sync_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            din_dv  = 1'($urandom);
            sync_in = 1'($urandom);
            din_dr  = 18'($urandom);
            din_di  = 18'($urandom);
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (q_dv[k] !== 1'b0 || q_sy[k] !== 1'b0 || q_er[k] !== 1'b0 ||
                    q_dr[k] !== 0 || q_di[k] !== 0) begin
                    bad++;
                    $display("FAIL reset inst%0d cyc%0d got dv=%b sy=%b er=%b dr=%0d di=%0d want all 0",
                             k, c, q_dv[k], q_sy[k], q_er[k], q_dr[k], q_di[k]);
                end
            end
        end
        din_dv  = 1'b0;
        sync_in = 1'b0;
        din_dr  = '0;
        din_di  = '0;
        rst_n   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        n = 0;
        add(1, 1, 100, -50);
        add(1, 0, 20, 30);
        add(1, 0, 5, -7);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0);
        run_stim();
        total++;
        if (o_dv[0][1] !== 1'b0 || o_dv[0][5] !== 1'b0) begin
            bad++;
            $display("FAIL basic_dv_edges got t+2=%b t+6=%b want 0,0", o_dv[0][1], o_dv[0][5]);
        end
        total++;
        if (o_dv[0][2] !== 1'b1 || o_dv[0][3] !== 1'b1 || o_dv[0][4] !== 1'b1) begin
            bad++;
            $display("FAIL basic_dv got %b%b%b want 111", o_dv[0][2], o_dv[0][3], o_dv[0][4]);
        end
        total++;
        if (o_sy[0][2] !== 1'b1 || o_sy[0][3] !== 1'b0 || o_sy[0][4] !== 1'b0) begin
            bad++;
            $display("FAIL basic_sync got %b%b%b want 100", o_sy[0][2], o_sy[0][3], o_sy[0][4]);
        end
        total++;
        if (o_dr[0][2] !== 100 || o_di[0][2] !== -50) begin
            bad++;
            $display("FAIL basic_x0 got (%0d,%0d) want (100,-50)", o_dr[0][2], o_di[0][2]);
        end
        total++;
        if (o_dr[0][3] !== 25 || o_di[0][3] !== 23) begin
            bad++;
            $display("FAIL basic_x1 got (%0d,%0d) want (25,23)", o_dr[0][3], o_di[0][3]);
        end
        total++;
        if (o_dr[0][4] !== 15 || o_di[0][4] !== 37) begin
            bad++;
            $display("FAIL basic_x2 got (%0d,%0d) want (15,37)", o_dr[0][4], o_di[0][4]);
        end
        total++;
        if (o_dr[1][2] !== 50 || o_di[1][2] !== -25 || o_dr[1][3] !== 13 || o_di[1][3] !== 12 ||
            o_dr[1][4] !== 8 || o_di[1][4] !== 19) begin
            bad++;
            $display("FAIL basic_scaled got (%0d,%0d)(%0d,%0d)(%0d,%0d) want (50,-25)(13,12)(8,19)",
                     o_dr[1][2], o_di[1][2], o_dr[1][3], o_di[1][3], o_dr[1][4], o_di[1][4]);
        end
        total++;
        if (o_dr[2][3] !== 15 || o_di[2][3] !== 37 || o_dr[2][4] !== 25 || o_di[2][4] !== 23) begin
            bad++;
            $display("FAIL inverse got X1=(%0d,%0d) X2=(%0d,%0d) want (15,37) (25,23)",
                     o_dr[2][3], o_di[2][3], o_dr[2][4], o_di[2][4]);
        end
        total++;
        if (o_dr[0][6] !== 15 || o_di[0][6] !== 37 || o_dv[0][6] !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold got dv=%b (%0d,%0d) want 0 (15,37)", o_dv[0][6], o_dr[0][6], o_di[0][6]);
        end
    endtask

    task automatic test_saturation();
        n = 0;
        add(1, 1, 0, 0);
        add(1, 0, 131071, -131072);
        add(1, 0, 10, -10);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0);
        run_stim();
        total++;
        if (o_dr[0][3] !== 131071 || o_di[0][3] !== -131072) begin
            bad++;
            $display("FAIL sat_x1 got (%0d,%0d) want (131071,-131072)", o_dr[0][3], o_di[0][3]);
        end
        total++;
        if (o_dr[0][4] !== 131061 || o_di[0][4] !== -131062) begin
            bad++;
            $display("FAIL sat_x2 got (%0d,%0d) want (131061,-131062)", o_dr[0][4], o_di[0][4]);
        end
        total++;
        if (o_dr[1][3] !== 65541 || o_di[1][3] !== -65541) begin
            bad++;
            $display("FAIL scale_x1 got (%0d,%0d) want (65541,-65541)", o_dr[1][3], o_di[1][3]);
        end
        total++;
        if (o_dr[1][4] !== 65531 || o_di[1][4] !== -65531) begin
            bad++;
            $display("FAIL scale_x2 got (%0d,%0d) want (65531,-65531)", o_dr[1][4], o_di[1][4]);
        end
    endtask

    task automatic test_back_to_back();
        n = 0;
        add(1, 1, 100, -50); add(1, 0, 20, 30); add(1, 0, 5, -7);
        add(1, 1, 1, 2);     add(1, 0, 3, 4);   add(1, 0, 5, 6);
        for (int i = 0; i < 7; i++) add(0, (i == 2), 0, 0);
        add(1, 1, 7, 7);     add(1, 0, 1, 1);   add(1, 0, 2, 2);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0);
        run_stim();
        for (int i = 0; i < n - 2; i++) begin
            total++;
            if (o_dv[0][i+2] !== s_dv[i] || o_sy[0][i+2] !== (s_dv[i] && s_sy[i])) begin
                bad++;
                $display("FAIL b2b_pattern slot%0d got dv=%b sy=%b want dv=%b sy=%b",
                         i, o_dv[0][i+2], o_sy[0][i+2], s_dv[i], s_dv[i] && s_sy[i]);
            end
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (o_er[0][i] !== 1'b0 || o_er[1][i] !== 1'b0 || o_er[2][i] !== 1'b0) begin
                bad++;
                $display("FAIL b2b_err cyc%0d got %b%b%b want 000", i, o_er[0][i], o_er[1][i], o_er[2][i]);
            end
        end
        total++;
        if (o_dr[0][6] !== 8 || o_di[0][6] !== 10 || o_dr[0][7] !== -2 || o_di[0][7] !== -2) begin
            bad++;
            $display("FAIL b2b_t2 got X1=(%0d,%0d) X2=(%0d,%0d) want (8,10) (-2,-2)",
                     o_dr[0][6], o_di[0][6], o_dr[0][7], o_di[0][7]);
        end
        total++;
        if (o_dr[0][16] !== 3 || o_di[0][16] !== 3 || o_dr[0][17] !== -1 || o_di[0][17] !== -1) begin
            bad++;
            $display("FAIL b2b_t3 got X1=(%0d,%0d) X2=(%0d,%0d) want (3,3) (-1,-1)",
                     o_dr[0][16], o_di[0][16], o_dr[0][17], o_di[0][17]);
        end
    endtask

    task automatic test_truncated();
        n = 0;
        add(1, 1, 40, -40);
        add(1, 0, 9, 9);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0);
        run_stim();
        total++;
        if (o_er[0][1] !== 1'b0 || o_er[0][2] !== 1'b1 || o_er[0][3] !== 1'b0) begin
            bad++;
            $display("FAIL e1_err got %b%b%b want 010", o_er[0][1], o_er[0][2], o_er[0][3]);
        end
        total++;
        if (o_dv[0][2] !== 1'b1 || o_dr[0][2] !== 40 || o_di[0][2] !== -40) begin
            bad++;
            $display("FAIL e1_x0 got dv=%b (%0d,%0d) want 1 (40,-40)", o_dv[0][2], o_dr[0][2], o_di[0][2]);
        end
        total++;
        if (o_dv[0][3] !== 1'b0 || o_dv[0][4] !== 1'b0 || o_dr[0][4] !== 40 || o_di[0][4] !== -40) begin
            bad++;
            $display("FAIL e1_drop got dv=%b%b val=(%0d,%0d) want 00 (40,-40)",
                     o_dv[0][3], o_dv[0][4], o_dr[0][4], o_di[0][4]);
        end
    endtask

    task automatic test_early_sync();
        n = 0;
        add(1, 1, 11, 12);
        add(1, 0, 50, 50);
        add(1, 1, 100, -50);
        add(1, 0, 20, 30);
        add(1, 0, 5, -7);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0);
        run_stim();
        total++;
        if (o_er[0][2] !== 1'b1 || o_er[0][3] !== 1'b0 || o_er[0][4] !== 1'b0) begin
            bad++;
            $display("FAIL e2_err got %b%b%b want 100", o_er[0][2], o_er[0][3], o_er[0][4]);
        end
        total++;
        if (o_dv[0][2] !== 1'b1 || o_dr[0][2] !== 11 || o_dv[0][3] !== 1'b0) begin
            bad++;
            $display("FAIL e2_old got dv=%b%b x0r=%0d want 10 11", o_dv[0][2], o_dv[0][3], o_dr[0][2]);
        end
        total++;
        if (o_dv[0][4] !== 1'b1 || o_sy[0][4] !== 1'b1 || o_dr[0][4] !== 100 || o_di[0][4] !== -50) begin
            bad++;
            $display("FAIL e2_new_x0 got dv=%b sy=%b (%0d,%0d) want 1 1 (100,-50)",
                     o_dv[0][4], o_sy[0][4], o_dr[0][4], o_di[0][4]);
        end
        total++;
        if (o_dv[0][5] !== 1'b1 || o_dr[0][5] !== 25 || o_di[0][5] !== 23 ||
            o_dv[0][6] !== 1'b1 || o_dr[0][6] !== 15 || o_di[0][6] !== 37 || o_dv[0][7] !== 1'b0) begin
            bad++;
            $display("FAIL e2_new_x12 got %b(%0d,%0d) %b(%0d,%0d) %b want 1(25,23) 1(15,37) 0",
                     o_dv[0][5], o_dr[0][5], o_di[0][5], o_dv[0][6], o_dr[0][6], o_di[0][6], o_dv[0][7]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        din_dv  = 1'b0;
        sync_in = 1'b0;
        din_dr  = '0;
        din_di  = '0;
        #1;
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_truncated();
        test_early_sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
